// File: rtl/tank_pkg.sv
// ----------------------------------------------------------------------------
// tank_pkg
//   Shared types and constants for the N-player tank controller.
//   - dir_e    : facing, encoded so the value equals the bit index of the
//                matching move_i / blocked bit (0 down, 1 up, 2 right, 3 left)
//   - pstate_e : per-player life cycle
//   - body/probe offsets relative to a tank's upper-left corner
//   - step_clamp: one movement step with arena clamping (no wrap-around)
// ----------------------------------------------------------------------------
package tank_pkg;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'd0,
        DIR_UP    = 2'd1,
        DIR_RIGHT = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        SPAWN  = 2'd0,
        ACTIVE = 2'd1,
        DEAD   = 2'd2
    } pstate_e;

    // Body occupies offsets BODY_LO..BODY_HI on both axes; probes sit one
    // pixel outside the body on each side.
    localparam logic [9:0] BODY_LO    = 10'd2;
    localparam logic [9:0] BODY_HI    = 10'd29;
    localparam logic [9:0] PROBE_NEAR = 10'd1;
    localparam logic [9:0] PROBE_FAR  = 10'd30;

    // Bit positions inside move_i nibbles and blocked flags.
    localparam int unsigned BLK_BOTTOM = 0;
    localparam int unsigned BLK_TOP    = 1;
    localparam int unsigned BLK_RIGHT  = 2;
    localparam int unsigned BLK_LEFT   = 3;

    function automatic dir_e onehot_to_dir(input logic [3:0] m);
        unique case (m)
            4'b0001: return DIR_DOWN;
            4'b0010: return DIR_UP;
            4'b0100: return DIR_RIGHT;
            default: return DIR_LEFT;
        endcase
    endfunction

    // Signed intermediate so a step below zero or past the top saturates
    // instead of wrapping in 10 bits.
    function automatic logic [9:0] step_clamp(input logic [9:0]  pos,
                                              input logic        inc,
                                              input int unsigned speed,
                                              input int unsigned lo,
                                              input int unsigned hi);
        int p;
        p = inc ? (int'(pos) + int'(speed)) : (int'(pos) - int'(speed));
        if (p < int'(lo)) p = int'(lo);
        if (p > int'(hi)) p = int'(hi);
        return p[9:0];
    endfunction

endpackage

// File: rtl/tank_player_array_if.sv
// ----------------------------------------------------------------------------
// tank_player_array_if
//   Raster/video side of the tank controller.
//   master (raster source / mixer): drives frame_start, display_enable,
//          hpos, vpos, cannot_walk_through; receives player_red/green/blue
//   slave  (tank_player_array)    : the reverse
// ----------------------------------------------------------------------------
interface tank_player_array_if #(
    parameter int unsigned COLOR_BITS = 24
);
    logic                    frame_start;
    logic                    display_enable;
    logic [9:0]              hpos;
    logic [9:0]              vpos;
    logic                    cannot_walk_through;
    logic [COLOR_BITS/3-1:0] player_red;
    logic [COLOR_BITS/3-1:0] player_green;
    logic [COLOR_BITS/3-1:0] player_blue;

    modport master (
        output frame_start, display_enable, hpos, vpos, cannot_walk_through,
        input  player_red, player_green, player_blue
    );

    modport slave (
        input  frame_start, display_enable, hpos, vpos, cannot_walk_through,
        output player_red, player_green, player_blue
    );
endinterface

// File: rtl/tank_player_unit.sv
// ----------------------------------------------------------------------------
// tank_player_unit
//   One tank: life-cycle FSM, position/facing, wall probes and committed
//   blocked flags.
//   Ports:
//     clk_i, reset_i        clock, synchronous active-high reset
//     move_tick_i           movement strobe
//     frame_start_i         commits sampled probe hits into blocked_o
//     display_enable_i      raster visible
//     hpos_i, vpos_i        raster position
//     solid_i               pixel at (hpos,vpos) counts as solid
//     move_i                one-hot {left,right,up,down}
//     hit_i                 kill pulse
//     x_o, y_o, dir_o       position (upper-left corner) and facing
//     alive_o               1 in ACTIVE
//     blocked_o             {left,right,top,bottom}
//     occ_o                 raster pixel is in this tank's body and tank is not DEAD
//     show_o                tank is currently visible (ACTIVE, or SPAWN blink phase)
// ----------------------------------------------------------------------------
module tank_player_unit
    import tank_pkg::*;
#(
    parameter logic [9:0]  X_INIT        = 10'd224,
    parameter logic [9:0]  Y_INIT        = 10'd64,
    parameter int unsigned MOVE_SPEED    = 1,
    parameter int unsigned X_MIN         = 0,
    parameter int unsigned X_MAX         = 608,
    parameter int unsigned Y_MIN         = 0,
    parameter int unsigned Y_MAX         = 448,
    parameter int unsigned SPAWN_TICKS   = 64,
    parameter int unsigned RESPAWN_TICKS = 128
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       move_tick_i,
    input  logic       frame_start_i,
    input  logic       display_enable_i,
    input  logic [9:0] hpos_i,
    input  logic [9:0] vpos_i,
    input  logic       solid_i,
    input  logic [3:0] move_i,
    input  logic       hit_i,
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output logic [1:0] dir_o,
    output logic       alive_o,
    output logic [3:0] blocked_o,
    output logic       occ_o,
    output logic       show_o
);

    localparam int unsigned CNT_MAX = (SPAWN_TICKS > RESPAWN_TICKS) ? SPAWN_TICKS : RESPAWN_TICKS;
    // At least 4 bits so the spawn blink bit cnt[3] always exists.
    localparam int unsigned CNT_W   = ($clog2(CNT_MAX + 1) < 4) ? 4 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SPAWN_CNT   = CNT_W'(SPAWN_TICKS);
    localparam logic [CNT_W-1:0] RESPAWN_CNT = CNT_W'(RESPAWN_TICKS);

    pstate_e          state_q;
    dir_e             dir_q;
    logic [9:0]       x_q, y_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       blocked_q, pend_q;

    logic [9:0] dx, dy;
    logic       dx_in, dy_in, body;
    logic [3:0] probe, hits;
    logic       move_valid;
    dir_e       move_dir;
    logic [9:0] x_d, y_d;

    // Raster offsets relative to the tank corner, 10-bit modulo.
    always_comb begin
        dx    = hpos_i - x_q;
        dy    = vpos_i - y_q;
        dx_in = (dx >= BODY_LO) && (dx <= BODY_HI);
        dy_in = (dy >= BODY_LO) && (dy <= BODY_HI);
        body  = dx_in && dy_in;

        probe             = '0;
        probe[BLK_TOP]    = dx_in && (dy == PROBE_NEAR);
        probe[BLK_BOTTOM] = dx_in && (dy == PROBE_FAR);
        probe[BLK_LEFT]   = dy_in && (dx == PROBE_NEAR);
        probe[BLK_RIGHT]  = dy_in && (dx == PROBE_FAR);

        hits = (state_q != DEAD && display_enable_i && solid_i) ? probe : '0;
    end

    // Candidate position for an accepted move; FSM decides whether to take it.
    always_comb begin
        move_valid = $onehot(move_i);
        move_dir   = onehot_to_dir(move_i);
        x_d        = x_q;
        y_d        = y_q;
        if (move_valid && !blocked_q[move_dir]) begin
            unique case (move_dir)
                DIR_DOWN:  y_d = step_clamp(y_q, 1'b1, MOVE_SPEED, Y_MIN, Y_MAX);
                DIR_UP:    y_d = step_clamp(y_q, 1'b0, MOVE_SPEED, Y_MIN, Y_MAX);
                DIR_RIGHT: x_d = step_clamp(x_q, 1'b1, MOVE_SPEED, X_MIN, X_MAX);
                default:   x_d = step_clamp(x_q, 1'b0, MOVE_SPEED, X_MIN, X_MAX);
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= SPAWN;
            dir_q     <= DIR_UP;
            x_q       <= X_INIT;
            y_q       <= Y_INIT;
            cnt_q     <= SPAWN_CNT;
            blocked_q <= '0;
            pend_q    <= '0;
        end else begin
            if (frame_start_i) begin
                blocked_q <= pend_q | hits;
                pend_q    <= '0;
            end else begin
                pend_q <= pend_q | hits;
            end

            unique case (state_q)
                SPAWN: begin
                    if (cnt_q == '0)      state_q <= ACTIVE;
                    else if (move_tick_i) cnt_q   <= cnt_q - CNT_W'(1);
                end
                ACTIVE: begin
                    // A kill in the same cycle as a tick suppresses the move.
                    if (hit_i) begin
                        state_q <= DEAD;
                        cnt_q   <= RESPAWN_CNT;
                    end else if (move_tick_i && move_valid) begin
                        dir_q <= move_dir;
                        x_q   <= x_d;
                        y_q   <= y_d;
                    end
                end
                DEAD: begin
                    if (cnt_q == '0) begin
                        state_q   <= SPAWN;
                        cnt_q     <= SPAWN_CNT;
                        x_q       <= X_INIT;
                        y_q       <= Y_INIT;
                        blocked_q <= '0;
                        pend_q    <= '0;
                    end else if (move_tick_i) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= SPAWN;
            endcase
        end
    end

    assign x_o       = x_q;
    assign y_o       = y_q;
    assign dir_o     = dir_q;
    assign alive_o   = (state_q == ACTIVE);
    assign blocked_o = blocked_q;
    assign occ_o     = body && (state_q != DEAD);
    assign show_o    = (state_q == ACTIVE) || (state_q == SPAWN && cnt_q[3]);

endmodule

// File: rtl/tank_player_array.sv
// ----------------------------------------------------------------------------
// tank_player_array
//   N-player tank controller: one tank_player_unit per player, colour
//   priority mux (lowest index wins) and optional tank-to-tank blocking.
//   Build option: define TANK_COLLIDE_EN to make a probe pixel solid when it
//   lies in the body of any other ACTIVE/SPAWN player; undefined, only map
//   pixels block.
//   Ports:
//     clk_i, reset_i   clock, synchronous active-high reset
//     move_tick_i      movement strobe
//     move_i           4*N one-hot {left,right,up,down} per player
//     hit_i            N kill pulses
//     vid              raster in / pixel colour out (slave modport)
//     player_x_o/_y_o  10*N positions, player_dir_o 2*N facing
//     player_alive_o   N, blocked_o 4*N {left,right,top,bottom}
// ----------------------------------------------------------------------------
module tank_player_array
    import tank_pkg::*;
#(
    parameter int unsigned                       NUM_PLAYERS   = 2,
    parameter int unsigned                       COLOR_BITS    = 24,
    parameter logic [10*NUM_PLAYERS-1:0]         X_INIT        = {10'd224, 10'd224},
    parameter logic [10*NUM_PLAYERS-1:0]         Y_INIT        = {10'd416, 10'd64},
    parameter int unsigned                       MOVE_SPEED    = 1,
    parameter int unsigned                       X_MIN         = 0,
    parameter int unsigned                       X_MAX         = 608,
    parameter int unsigned                       Y_MIN         = 0,
    parameter int unsigned                       Y_MAX         = 448,
    parameter int unsigned                       SPAWN_TICKS   = 64,
    parameter int unsigned                       RESPAWN_TICKS = 128,
    parameter logic [COLOR_BITS*NUM_PLAYERS-1:0] PLAYER_COLORS = {24'hFFFF00, 24'h00FF00}
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       move_tick_i,
    input  logic [4*NUM_PLAYERS-1:0]   move_i,
    input  logic [NUM_PLAYERS-1:0]     hit_i,
    tank_player_array_if.slave         vid,
    output logic [10*NUM_PLAYERS-1:0]  player_x_o,
    output logic [10*NUM_PLAYERS-1:0]  player_y_o,
    output logic [2*NUM_PLAYERS-1:0]   player_dir_o,
    output logic [NUM_PLAYERS-1:0]     player_alive_o,
    output logic [4*NUM_PLAYERS-1:0]   blocked_o
);

    localparam int unsigned CH = COLOR_BITS / 3;

    logic [NUM_PLAYERS-1:0] occ, show, draw;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic solid;
`ifdef TANK_COLLIDE_EN
        logic [NUM_PLAYERS-1:0] others;
        always_comb begin
            others    = occ;
            others[p] = 1'b0;
        end
        assign solid = vid.cannot_walk_through | (|others);
`else
        assign solid = vid.cannot_walk_through;
`endif

        tank_player_unit #(
            .X_INIT        (X_INIT[10*p +: 10]),
            .Y_INIT        (Y_INIT[10*p +: 10]),
            .MOVE_SPEED    (MOVE_SPEED),
            .X_MIN         (X_MIN),
            .X_MAX         (X_MAX),
            .Y_MIN         (Y_MIN),
            .Y_MAX         (Y_MAX),
            .SPAWN_TICKS   (SPAWN_TICKS),
            .RESPAWN_TICKS (RESPAWN_TICKS)
        ) u_unit (
            .clk_i            (clk_i),
            .reset_i          (reset_i),
            .move_tick_i      (move_tick_i),
            .frame_start_i    (vid.frame_start),
            .display_enable_i (vid.display_enable),
            .hpos_i           (vid.hpos),
            .vpos_i           (vid.vpos),
            .solid_i          (solid),
            .move_i           (move_i[4*p +: 4]),
            .hit_i            (hit_i[p]),
            .x_o              (player_x_o[10*p +: 10]),
            .y_o              (player_y_o[10*p +: 10]),
            .dir_o            (player_dir_o[2*p +: 2]),
            .alive_o          (player_alive_o[p]),
            .blocked_o        (blocked_o[4*p +: 4]),
            .occ_o            (occ[p]),
            .show_o           (show[p])
        );
    end

    assign draw = occ & show;

    logic [COLOR_BITS-1:0] pix;

    // Walk from the highest index down so the lowest drawn index is written last.
    always_comb begin
        pix = '0;
        for (int unsigned i = NUM_PLAYERS; i > 0; i--) begin
            if (draw[i-1]) pix = PLAYER_COLORS[COLOR_BITS*(i-1) +: COLOR_BITS];
        end
        if (!vid.display_enable) pix = '0;
    end

    assign vid.player_red   = pix[3*CH-1 -: CH];
    assign vid.player_green = pix[2*CH-1 -: CH];
    assign vid.player_blue  = pix[CH-1:0];

endmodule
